// File: rtl/exec_sequencer.sv
// Multi-cycle instruction sequencer: fetches 16-bit instructions, drives an external
// registered ALU and a data memory port, and owns the 16-entry register file.
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 16
`endif
`ifndef INSTR_ADD
`define INSTR_ADD   4'h0
`define INSTR_SUB   4'h1
`define INSTR_AND   4'h2
`define INSTR_OR    4'h3
`define INSTR_XOR   4'h4
`define INSTR_ADDI  4'h5
`define INSTR_BEQ   4'h6
`define INSTR_BNE   4'h7
`define INSTR_LOAD  4'h8
`define INSTR_STORE 4'h9
`define INSTR_HALT  4'hF
`endif

module exec_sequencer #(
    parameter int unsigned DATA_W = `DATA_BUS_WIDTH,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic              illegal_op
);
    localparam int unsigned NREG = 16;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, WB, MEM, HALT} state_t;

    state_t            state, state_d;
    logic [15:0]       ir;
    logic [DATA_W-1:0] rf [NREG];
    logic              imem_req_d, dmem_req_d, dmem_we_d, halted_d, illegal_d;
    logic              fetch_done, mem_done;
    logic [3:0]        op, rd, rs, rt;
    logic [ADDR_W-1:0] br_off;

    function automatic logic op_legal(input logic [3:0] o);
        case (o)
            `INSTR_ADD, `INSTR_SUB, `INSTR_AND, `INSTR_OR, `INSTR_XOR, `INSTR_ADDI,
            `INSTR_BEQ, `INSTR_BNE, `INSTR_LOAD, `INSTR_STORE, `INSTR_HALT: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    endfunction

    function automatic logic is_alu_op(input logic [3:0] o);
        is_alu_op = (o == `INSTR_ADD) || (o == `INSTR_SUB) || (o == `INSTR_AND) ||
                    (o == `INSTR_OR)  || (o == `INSTR_XOR) || (o == `INSTR_ADDI);
    endfunction

    function automatic logic is_branch(input logic [3:0] o);
        is_branch = (o == `INSTR_BEQ) || (o == `INSTR_BNE);
    endfunction

    function automatic logic is_mem_op(input logic [3:0] o);
        is_mem_op = (o == `INSTR_LOAD) || (o == `INSTR_STORE);
    endfunction

    assign op         = ir[15:12];
    assign rd         = ir[11:8];
    assign rs         = ir[7:4];
    assign rt         = ir[3:0];
    assign br_off     = {{(ADDR_W-4){rt[3]}}, rt};
    assign imem_addr  = pc;
    // ALU output is registered and its operands are held through MEM, so it is stable here
    assign dmem_addr  = alu_result[ADDR_W-1:0];
    assign fetch_done = (state == FETCH) && imem_req && imem_valid;
    assign mem_done   = (state == MEM) && dmem_req && dmem_ack;

    // State and handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            imem_req   <= 1'b0;
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            halted     <= 1'b0;
            illegal_op <= 1'b0;
        end else begin
            state      <= state_d;
            imem_req   <= imem_req_d;
            dmem_req   <= dmem_req_d;
            dmem_we    <= dmem_we_d;
            halted     <= halted_d;
            illegal_op <= illegal_d;
        end
    end

    // Next state; outputs are computed one edge ahead so they are valid on state entry
    always_comb begin
        state_d    = state;
        imem_req_d = 1'b0;
        dmem_req_d = 1'b0;
        dmem_we_d  = dmem_we;
        halted_d   = 1'b0;
        illegal_d  = 1'b0;
        case (state)
            FETCH: begin
                imem_req_d = 1'b1;
                if (fetch_done) begin
                    imem_req_d = 1'b0;
                    illegal_d  = !op_legal(imem_rdata[15:12]);
                    state_d    = DECODE;
                end
            end
            DECODE: begin
                if (op == `INSTR_HALT) begin
                    halted_d = 1'b1;
                    state_d  = HALT;
                end else if (!op_legal(op)) begin
                    imem_req_d = 1'b1;
                    state_d    = FETCH;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (is_mem_op(op)) begin
                    dmem_req_d = 1'b1;
                    dmem_we_d  = (op == `INSTR_STORE);
                    state_d    = MEM;
                end else begin
                    state_d = WB;
                end
            end
            WB: begin
                imem_req_d = 1'b1;
                state_d    = FETCH;
            end
            MEM: begin
                dmem_req_d = 1'b1;
                if (mem_done) begin
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    imem_req_d = 1'b1;
                    state_d    = FETCH;
                end
            end
            HALT:    halted_d = 1'b1;
            default: state_d  = FETCH;
        endcase
    end

    // Datapath: IR, PC, operand registers, store data and register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir         <= '0;
            pc         <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            dmem_wdata <= '0;
            rf         <= '{default: '0};
        end else begin
            if (fetch_done) begin
                ir <= imem_rdata;
                pc <= pc + ADDR_W'(1);
            end
            if (state == DECODE && op_legal(op) && op != `INSTR_HALT) begin
                alu_ctrl <= is_mem_op(op) ? `INSTR_ADD : op;
                alu_a    <= is_branch(op) ? rf[rd] : rf[rs];
                if (is_branch(op))
                    alu_b <= rf[rs];
                else if (op == `INSTR_ADDI || is_mem_op(op))
                    alu_b <= DATA_W'(rt);
                else
                    alu_b <= rf[rt];
            end
            if (state == EXEC)
                dmem_wdata <= rf[rd];
            if (state == WB) begin
                if (is_alu_op(op) && rd != 4'd0)
                    rf[rd] <= alu_result;
                if (is_branch(op) && alu_result[0])
                    pc <= pc + br_off;
            end
            if (mem_done && op == `INSTR_LOAD && rd != 4'd0)
                rf[rd] <= dmem_rdata;
        end
    end
endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer with behavioural ALU and instruction/data memories.
module tb_exec_sequencer;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ADDR_W = 8;
    localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR = 4'h3,
                           OP_XOR = 4'h4, OP_ADDI = 4'h5, OP_BEQ = 4'h6, OP_BNE = 4'h7,
                           OP_LOAD = 4'h8, OP_STORE = 4'h9, OP_HALT = 4'hF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              imem_req, imem_valid, dmem_req, dmem_we, dmem_ack;
    logic              halted, illegal_op;
    logic [ADDR_W-1:0] imem_addr, dmem_addr, pc;
    logic [15:0]       imem_rdata;
    logic [DATA_W-1:0] dmem_wdata, dmem_rdata, alu_a, alu_b, alu_result;
    logic [3:0]        alu_ctrl;

    logic [15:0]       imem [256];
    logic [DATA_W-1:0] dmem [256];
    logic              imem_en = 1'b1;
    logic              mon_mem = 1'b0;
    int                dmem_lat = 0;
    int                dcnt = 0, cyc = 0, ill_cnt = 0, st_cycles = 0, mem_bad = 0;
    logic [ADDR_W-1:0] fq [$];
    int                fc [$];
    int                passed = 0, total = 0;

    exec_sequencer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_result(alu_result),
        .pc(pc), .halted(halted), .illegal_op(illegal_op)
    );

    assign imem_valid = imem_req & imem_en;
    assign imem_rdata = imem[imem_addr];
    assign dmem_rdata = dmem[dmem_addr];
    assign dmem_ack   = dmem_req && (dcnt >= dmem_lat);

    // Reference ALU: result registered one clock after operands
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alu_result <= '0;
        else begin
            case (alu_ctrl)
                OP_ADD, OP_ADDI: alu_result <= alu_a + alu_b;
                OP_SUB:          alu_result <= alu_a - alu_b;
                OP_AND:          alu_result <= alu_a & alu_b;
                OP_OR:           alu_result <= alu_a | alu_b;
                OP_XOR:          alu_result <= alu_a ^ alu_b;
                OP_BEQ:          alu_result <= {15'd0, alu_a == alu_b};
                OP_BNE:          alu_result <= {15'd0, alu_a != alu_b};
                default:         alu_result <= '0;
            endcase
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && imem_req && imem_valid) begin
            fq.push_back(imem_addr);
            fc.push_back(cyc);
        end
        if (!dmem_req || dmem_ack) dcnt <= 0;
        else dcnt <= dcnt + 1;
        if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr] <= dmem_wdata;
    end

    always @(negedge clk) begin
        if (illegal_op) ill_cnt <= ill_cnt + 1;
        if (dmem_req && dmem_we) st_cycles <= st_cycles + 1;
        if (mon_mem && dmem_req && (dmem_addr !== 8'd4 || (dmem_we && dmem_wdata !== 16'd9)))
            mem_bad <= mem_bad + 1;
    end

    function automatic logic [15:0] ins(input logic [3:0] o, input logic [3:0] d,
                                        input logic [3:0] s, input logic [3:0] t);
        ins = {o, d, s, t};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    endtask

    task automatic wait_halt(input int budget);
        int n = 0;
        while (!halted && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("halt_wait", {31'd0, halted}, 32'd1);
    endtask

    task automatic wait_fq(input int need, input int budget);
        int n = 0;
        while (fq.size() < need && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_wait", {31'd0, fq.size() >= need}, 32'd1);
    endtask

    initial begin
        int base, ill0, st0, bad0, n;
        logic stable;
        logic [ADDR_W-1:0] exp_seq [8];

        // A: ALU timing, SUB result, zero-wait STORE, HALT
        clear_imem();
        imem[0] = ins(OP_ADDI, 4'd1, 4'd0, 4'd5);
        imem[1] = ins(OP_ADDI, 4'd2, 4'd0, 4'd3);
        imem[2] = ins(OP_SUB,  4'd3, 4'd1, 4'd2);
        imem[3] = ins(OP_STORE, 4'd3, 4'd0, 4'd1);
        imem[4] = ins(OP_HALT, 4'd0, 4'd0, 4'd0);
        repeat (2) @(negedge clk);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_dmem_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_dmem_we", {31'd0, dmem_we}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_illegal", {31'd0, illegal_op}, 32'd0);
        chk("rst_pc", {24'd0, pc}, 32'd0);
        chk("rst_alu", {alu_a, alu_b} | {28'd0, alu_ctrl}, 32'd0);
        base = fq.size();
        rst_n = 1'b1;
        wait_halt(100);
        chk("A_r3", {16'd0, dut.rf[3]}, 32'd2);
        chk("A_t01", fc[base+1] - fc[base], 32'd4);
        chk("A_t12", fc[base+2] - fc[base+1], 32'd4);
        chk("A_t23", fc[base+3] - fc[base+2], 32'd4);
        chk("A_store_t", fc[base+4] - fc[base+3], 32'd4);
        chk("A_dmem1", {16'd0, dmem[1]}, 32'd2);
        chk("A_pc", {24'd0, pc}, 32'd5);
        repeat (5) @(negedge clk);
        chk("A_halt_noreq", {31'd0, imem_req}, 32'd0);
        chk("A_halt_nofetch", fq.size(), base + 5);

        // B: BEQ taken back to 3, then not taken to 5
        rst_n = 1'b0;
        @(negedge clk);
        clear_imem();
        imem[0] = ins(OP_ADDI, 4'd1, 4'd0, 4'd6);
        imem[1] = ins(OP_ADDI, 4'd2, 4'd0, 4'd7);
        imem[3] = ins(OP_ADDI, 4'd1, 4'd1, 4'd1);
        imem[4] = ins(OP_BEQ,  4'd1, 4'd2, 4'hE);
        imem[5] = ins(OP_HALT, 4'd0, 4'd0, 4'd0);
        base = fq.size();
        rst_n = 1'b1;
        wait_halt(200);
        exp_seq = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd3, 8'd4, 8'd5};
        for (int k = 0; k < 8; k++) chk($sformatf("B_fetch%0d", k), {24'd0, fq[base+k]}, {24'd0, exp_seq[k]});
        chk("B_branch_t", fc[base+5] - fc[base+4], 32'd4);
        chk("B_pc", {24'd0, pc}, 32'd6);

        // C: STORE/LOAD with 3-cycle ack delay, illegal opcode, HALT
        rst_n = 1'b0;
        @(negedge clk);
        clear_imem();
        imem[0] = ins(OP_ADDI,  4'd1, 4'd0, 4'd9);
        imem[1] = ins(OP_STORE, 4'd1, 4'd0, 4'd4);
        imem[2] = ins(OP_LOAD,  4'd5, 4'd0, 4'd4);
        imem[3] = ins(4'hA,     4'd0, 4'd0, 4'd0);
        imem[4] = ins(OP_HALT,  4'd0, 4'd0, 4'd0);
        dmem_lat = 3;
        mon_mem = 1'b1;
        ill0 = ill_cnt; st0 = st_cycles; bad0 = mem_bad;
        base = fq.size();
        rst_n = 1'b1;
        wait_halt(200);
        @(negedge clk);
        mon_mem = 1'b0;
        chk("C_r5", {16'd0, dut.rf[5]}, 32'd9);
        chk("C_dmem4", {16'd0, dmem[4]}, 32'd9);
        chk("C_mem_stable", mem_bad - bad0, 32'd0);
        chk("C_store_req_cycles", st_cycles - st0, 32'd4);
        chk("C_store_t", fc[base+2] - fc[base+1], 32'd7);
        chk("C_load_t", fc[base+3] - fc[base+2], 32'd7);
        chk("C_illegal_pulses", ill_cnt - ill0, 32'd1);
        chk("C_illegal_t", fc[base+4] - fc[base+3], 32'd2);
        chk("C_after_illegal", {24'd0, fq[base+4]}, 32'd4);

        // D: instruction fetch stalled for 5 cycles
        rst_n = 1'b0;
        @(negedge clk);
        clear_imem();
        imem[0] = ins(OP_ADDI, 4'd7, 4'd0, 4'd3);
        imem[1] = ins(OP_HALT, 4'd0, 4'd0, 4'd0);
        dmem_lat = 0;
        imem_en = 1'b0;
        base = fq.size();
        rst_n = 1'b1;
        @(negedge clk);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!(imem_req === 1'b1 && imem_addr === 8'd0 && pc === 8'd0 && halted === 1'b0)) stable = 1'b0;
        end
        chk("D_stall_stable", {31'd0, stable}, 32'd1);
        chk("D_no_fetch", fq.size(), base);
        imem_en = 1'b1;
        wait_halt(50);
        chk("D_r7", {16'd0, dut.rf[7]}, 32'd3);

        // E: reset while a data request is pending
        rst_n = 1'b0;
        @(negedge clk);
        clear_imem();
        imem[0] = ins(OP_ADDI, 4'd4, 4'd0, 4'd6);
        imem[1] = ins(OP_LOAD, 4'd5, 4'd0, 4'd4);
        dmem_lat = 20;
        rst_n = 1'b1;
        n = 0;
        while (!dmem_req && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("E_dreq_seen", {31'd0, dmem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("E_dreq_drop", {31'd0, dmem_req}, 32'd0);
        chk("E_pc_rst", {24'd0, pc}, 32'd0);
        chk("E_r4_r5", {dut.rf[4], dut.rf[5]}, 32'd0);
        dmem_lat = 0;
        @(negedge clk);
        base = fq.size();
        rst_n = 1'b1;
        wait_fq(base + 3, 40);
        chk("E_refetch0", {24'd0, fq[base]}, 32'd0);
        repeat (4) @(negedge clk);
        chk("E_load_r5", {16'd0, dut.rf[5]}, 32'd9);

        // F: branch to 255, PC wraps to 0
        rst_n = 1'b0;
        @(negedge clk);
        clear_imem();
        imem[0] = ins(OP_BEQ, 4'd0, 4'd0, 4'hE);
        base = fq.size();
        rst_n = 1'b1;
        wait_fq(base + 3, 40);
        chk("F_fetch255", {24'd0, fq[base+1]}, 32'd255);
        chk("F_wrap0", {24'd0, fq[base+2]}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/exec_sequencer.md
EXEC_SEQUENCER -- requirements
Module: exec_sequencer

Interface
REQ-001 The block SHALL have these parameters:
- DATA_W, 16, datapath width; equals `DATA_BUS_WIDTH.
- ADDR_W, 8, instruction and data address width.
REQ-002 The block SHALL have these ports, one per line:
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address (= PC).
- imem_rdata  in  16  instruction word.
- imem_valid  in  1  imem_rdata valid; completes a fetch.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  ADDR_W  data address.
- dmem_wdata  out  DATA_W  store data.
- dmem_rdata  in  DATA_W  load data.
- dmem_ack  in  1  completes a data access.
- alu_a  out  DATA_W  ALU operand A.
- alu_b  out  DATA_W  ALU operand B.
- alu_ctrl  out  4  ALU opcode, `INSTR_* encoding.
- alu_result  in  DATA_W  registered ALU output, valid one clock after the operands are presented.
- pc  out  ADDR_W  current PC.
- halted  out  1  high in HALT.
- illegal_op  out  1  one-cycle pulse on an undecoded opcode.

Function
REQ-003 Instruction format SHALL be [15:12] op, [11:8] rd, [7:4] rs, [3:0] rt/imm4; opcode values are the `INSTR_* macros.
REQ-004 The block SHALL contain a 16 x DATA_W register file; R0 reads 0 and ignores writes.
REQ-005 FSM states SHALL be FETCH, DECODE, EXEC, WB, MEM, HALT, with reset state FETCH.
REQ-006 FETCH:
- imem_req=1 with imem_addr=PC, both held stable until imem_valid.
- On imem_valid: IR<=imem_rdata, PC<=PC+1 (wraps modulo 2^ADDR_W), then DECODE.
REQ-007 imem_valid or dmem_ack arriving while the matching req is low SHALL be ignored.
REQ-008 DECODE SHALL register the operands and alu_ctrl, then go to EXEC:
- ADD/SUB/AND/OR/XOR: alu_a=R[rs], alu_b=R[rt].
- ADDI: alu_a=R[rs], alu_b=zext(imm4).
- Branches: alu_a=R[rd], alu_b=R[rs].
- LOAD/STORE: alu_ctrl=`INSTR_ADD, alu_a=R[rs], alu_b=zext(imm4).
REQ-009 EXEC SHALL hold alu_a, alu_b and alu_ctrl unchanged, lasting exactly one cycle, then go to WB (ALU ops, branches) or MEM (LOAD/STORE).
REQ-010 WB:
- ALU ops: R[rd]<=alu_result.
- Branches: if alu_result[0]=1, PC<=PC+sext(imm4), using the already-incremented PC; otherwise PC is unchanged.
- Next state is FETCH.
REQ-011 MEM:
- dmem_req=1, dmem_addr=alu_result[ADDR_W-1:0], dmem_we=1 for STORE, dmem_wdata=R[rd]; all held stable until dmem_ack.
- On ack, LOAD writes R[rd]<=dmem_rdata; next state is FETCH.
REQ-012 `INSTR_HALT SHALL enter HALT from DECODE; HALT is left only by reset.
REQ-013 An undecoded opcode SHALL pulse illegal_op in DECODE, act as NOP, and return to FETCH.
REQ-014 Timing, with imem_valid/dmem_ack returned in the same cycle as the request:
- ALU instruction or branch: 4 cycles.
- LOAD/STORE: 4 cycles.
REQ-015 A write to R[rd] SHALL be visible to the next instruction's DECODE.

Reset
REQ-016 Asserting rst_n=0 SHALL immediately (asynchronously) set:
- state=FETCH, PC=0, IR=0, all registers=0.
- imem_req=0, dmem_req=0, dmem_we=0, alu_a=0, alu_b=0, alu_ctrl=0, halted=0, illegal_op=0.
REQ-017 Reset asserted mid-handshake SHALL drop the request that cycle with no register write; the first fetch after release is from address 0.

Verification
REQ-018 Bench scenarios:
- ADDI R1,R0,5; ADDI R2,R0,3; SUB R3,R1,R2 -> R3=2, 4 cycles per instruction with zero-wait memory.
- BEQ R1,R2,-2 with R1=R2=7 at PC=4 -> next fetch at address 3; with R1=8 -> next fetch at 5.
- STORE R1(=9),R0,4, then LOAD R5,R0,4, with dmem_ack delayed 3 cycles -> dmem_addr=4, dmem_wdata=9 stable throughout; R5=9.
- imem_valid held off for 5 cycles -> imem_req/imem_addr stable; no state change.
- Undecoded opcode -> single illegal_op pulse, PC advances by 1; HALT -> halted=1, no further imem_req.
- rst_n pulled low during a pending dmem_req -> dmem_req=0 that cycle, no register written, refetch from 0 after release.
- PC=2^ADDR_W-1 fetch -> PC wraps to 0.
